// File: rtl/fu_dispatch_arbiter_pkg.sv
// Shared types and constants for the dispatch stage between issue_table and
// the functional units.
package fu_dispatch_arbiter_pkg;

  // Number of functional units, each with its own dispatch queue.
  localparam int NUM_FU    = 4;
  localparam int FU_IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Default entries per dispatch queue.
  localparam int DISPATCH_DEPTH = 4;

  // Instruction as registered by issue_table.
  typedef struct packed {
    logic [31:0]         pc;
    logic [7:0]          opcode;
    logic [4:0]          rd;
    logic [FU_IDX_W-1:0] func_unit;
  } issued_instruction_t;

  // Circular-buffer pointer increment with an explicit wrap at depth-1, so
  // depths that are not a power of two wrap correctly.
  function automatic int unsigned wrap_inc(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fu_dispatch_fifo.sv
// One per-FU dispatch queue: circular buffer with valid/ready head, a
// two-slot credit for the registered issue path, and a drop pulse when an
// enqueue hits a full queue without a same-cycle dequeue.
// DEPTH_P must be at least 2 for the credit to be meaningful.
module fu_dispatch_fifo
  import fu_dispatch_arbiter_pkg::*;
#(
  parameter int DEPTH_P = DISPATCH_DEPTH
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                flush_i,
  input  logic                enq,
  input  logic                deq,
  input  issued_instruction_t wr_data,
  output issued_instruction_t rd_data,
  output logic                valid,
  output logic                credit,
  output logic                drop
);

  localparam int PW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH_P);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH_P - 2);

  issued_instruction_t mem [DEPTH_P];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;

  logic deq_fire;
  logic full;
  logic enq_ok;

  // Handshake qualification: a full queue still accepts when its head
  // leaves in the same cycle; flush discards any arriving instruction.
  always_comb begin
    deq_fire = deq && (count != '0);
    full     = (count == FULL_CNT);
    enq_ok   = enq && !flush_i && (!full || deq_fire);
    drop     = enq && !flush_i && full && !deq_fire;
  end

  // Pointer and occupancy update; reset and flush empty the queue alike.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_ok) begin
        tail <= PW'(wrap_inc(32'(tail), DEPTH_P));
      end
      if (deq_fire) begin
        head <= PW'(wrap_inc(32'(head), DEPTH_P));
      end
      if (enq_ok && !deq_fire) begin
        count <= count + 1'b1;
      end else if (!enq_ok && deq_fire) begin
        count <= count - 1'b1;
      end
    end
  end

  // Entry storage; contents past the valid window are don't-care, so no reset.
  always_ff @(posedge clk_i) begin
    if (enq_ok) begin
      mem[tail] <= wr_data;
    end
  end

  // Head is presented straight from storage; credit looks only at count.
  always_comb begin
    rd_data = mem[head];
    valid   = (count != '0);
    credit  = (count <= CREDIT_MAX);
  end

endmodule

// File: rtl/fu_dispatch_arbiter.sv
// Dispatch buffering between issue_table and the functional units: one queue
// per FU, per-FU credit back to issue, flush of all in-flight work and a
// sticky overflow flag for enqueues dropped at a full queue.
module fu_dispatch_arbiter
  import fu_dispatch_arbiter_pkg::*;
#(
  parameter int DEPTH_P = DISPATCH_DEPTH
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  issued_instruction_t              instruction_i,
  input  logic [NUM_FU-1:0]                valid_i,
  output logic [NUM_FU-1:0]                fu_ready_o,
  input  logic                             flush_i,
  output issued_instruction_t [NUM_FU-1:0] fu_instruction_o,
  output logic [NUM_FU-1:0]                fu_valid_o,
  input  logic [NUM_FU-1:0]                fu_ready_i,
  output logic                             overflow_o
);

  logic [NUM_FU-1:0] drop;

  for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
    fu_dispatch_fifo #(
      .DEPTH_P (DEPTH_P)
    ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .enq     (valid_i[f]),
      .deq     (fu_ready_i[f]),
      .wr_data (instruction_i),
      .rd_data (fu_instruction_o[f]),
      .valid   (fu_valid_o[f]),
      .credit  (fu_ready_o[f]),
      .drop    (drop[f])
    );
  end

  // Sticky overflow: any queue dropping an enqueue sets it; only reset clears.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_o <= 1'b0;
    end else if (|drop) begin
      overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fu_dispatch_arbiter.sv
// Directed bench for fu_dispatch_arbiter: a depth-4 instance for the main
// scenarios and a depth-3 instance for pointer wrap on a non-power-of-two.
module tb_fu_dispatch_arbiter;
  import fu_dispatch_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                             reset_i;
  issued_instruction_t              instr;
  logic [NUM_FU-1:0]                valid_i;
  logic [NUM_FU-1:0]                fu_ready_o;
  logic                             flush_i;
  issued_instruction_t [NUM_FU-1:0] fu_instr;
  logic [NUM_FU-1:0]                fu_valid_o;
  logic [NUM_FU-1:0]                fu_ready_i;
  logic                             overflow_o;

  issued_instruction_t              instr3;
  logic [NUM_FU-1:0]                valid3;
  logic [NUM_FU-1:0]                fu_ready_o3;
  logic                             flush3;
  issued_instruction_t [NUM_FU-1:0] fu_instr3;
  logic [NUM_FU-1:0]                fu_valid3;
  logic [NUM_FU-1:0]                fu_ready_i3;
  logic                             overflow3;

  int n_vec = 0;
  int n_err = 0;

  fu_dispatch_arbiter #(.DEPTH_P(4)) u_dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .instruction_i    (instr),
    .valid_i          (valid_i),
    .fu_ready_o       (fu_ready_o),
    .flush_i          (flush_i),
    .fu_instruction_o (fu_instr),
    .fu_valid_o       (fu_valid_o),
    .fu_ready_i       (fu_ready_i),
    .overflow_o       (overflow_o)
  );

  fu_dispatch_arbiter #(.DEPTH_P(3)) u_dut3 (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .instruction_i    (instr3),
    .valid_i          (valid3),
    .fu_ready_o       (fu_ready_o3),
    .flush_i          (flush3),
    .fu_instruction_o (fu_instr3),
    .fu_valid_o       (fu_valid3),
    .fu_ready_i       (fu_ready_i3),
    .overflow_o       (overflow3)
  );

  function automatic issued_instruction_t mk(input logic [31:0] pc);
    issued_instruction_t t;
    t.pc        = pc;
    t.opcode    = pc[7:0] ^ 8'h5A;
    t.rd        = pc[4:0] ^ 5'h13;
    t.func_unit = pc[FU_IDX_W-1:0];
    return t;
  endfunction

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_fu1(input int n);
    fu_ready_i = '0;
    for (int i = 1; i <= n; i++) begin
      valid_i = 4'b0010;
      instr   = mk(32'(i));
      tick();
    end
    valid_i = '0;
  endtask

  task automatic drain_fu1(input int first, input int n, input string tag);
    fu_ready_i = 4'b0010;
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (fu_valid_o[1] !== 1'b1 || fu_instr[1] !== mk(32'(first + i))) begin
        n_err++;
        $display("FAIL %s drain[%0d]: valid=%b pc=0x%0h, want valid=1 pc=0x%0h",
                 tag, i, fu_valid_o[1], fu_instr[1].pc, first + i);
      end
      tick();
    end
    fu_ready_i = '0;
    n_vec++;
    if (fu_valid_o[1] !== 1'b0) begin
      n_err++;
      $display("FAIL %s empty_after_drain: valid=%b, want 0", tag, fu_valid_o[1]);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    n_vec++;
    if (fu_valid_o !== 4'b0000 || fu_ready_o !== 4'b1111 || overflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset: valid=%b ready=%b ovf=%b, want 0000 1111 0",
               fu_valid_o, fu_ready_o, overflow_o);
    end
    n_vec++;
    if (fu_valid3 !== 4'b0000 || fu_ready_o3 !== 4'b1111 || overflow3 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_d3: valid=%b ready=%b ovf=%b, want 0000 1111 0",
               fu_valid3, fu_ready_o3, overflow3);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_single_issue();
    valid_i = 4'b0001;
    instr   = mk(32'h10);
    tick();
    valid_i = '0;
    n_vec++;
    if (fu_valid_o !== 4'b0001 || fu_instr[0] !== mk(32'h10)) begin
      n_err++;
      $display("FAIL single_issue: valid=%b pc=0x%0h, want 0001 pc=0x10",
               fu_valid_o, fu_instr[0].pc);
    end
    fu_ready_i = 4'b0001;
    tick();
    fu_ready_i = '0;
    n_vec++;
    if (fu_valid_o !== 4'b0000) begin
      n_err++;
      $display("FAIL single_dequeue: valid=%b, want 0000", fu_valid_o);
    end
  endtask

  task automatic test_stall_full();
    logic [3:0] exp_ready [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    fu_ready_i = '0;
    for (int i = 1; i <= 4; i++) begin
      valid_i = 4'b0010;
      instr   = mk(32'(i));
      tick();
      n_vec++;
      if (fu_ready_o[1] !== exp_ready[i-1][0] || fu_valid_o[1] !== 1'b1 ||
          fu_instr[1] !== mk(32'd1)) begin
        n_err++;
        $display("FAIL stall_full[%0d]: credit=%b valid=%b head=0x%0h, want %b 1 0x1",
                 i, fu_ready_o[1], fu_valid_o[1], fu_instr[1].pc, exp_ready[i-1][0]);
      end
    end
    valid_i = '0;
    drain_fu1(1, 4, "stall_full");
  endtask

  task automatic test_full_enq_deq();
    fill_fu1(4);
    valid_i    = 4'b0010;
    instr      = mk(32'd5);
    fu_ready_i = 4'b0010;
    tick();
    valid_i    = '0;
    fu_ready_i = '0;
    n_vec++;
    if (overflow_o !== 1'b0 || fu_ready_o[1] !== 1'b0 || fu_instr[1] !== mk(32'd2)) begin
      n_err++;
      $display("FAIL full_enq_deq: ovf=%b credit=%b head=0x%0h, want 0 0 0x2",
               overflow_o, fu_ready_o[1], fu_instr[1].pc);
    end
    drain_fu1(2, 4, "full_enq_deq");
  endtask

  task automatic test_overflow();
    fill_fu1(4);
    valid_i = 4'b0010;
    instr   = mk(32'd99);
    tick();
    valid_i = '0;
    n_vec++;
    if (overflow_o !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_set: ovf=%b, want 1", overflow_o);
    end
    drain_fu1(1, 4, "overflow");
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_vec++;
    if (overflow_o !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_after_flush: ovf=%b, want 1", overflow_o);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    n_vec++;
    if (overflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_after_reset: ovf=%b, want 0", overflow_o);
    end
  endtask

  task automatic test_flush();
    logic [3:0] fill_pat [3] = '{4'b0111, 4'b0011, 4'b0001};
    fu_ready_i = '0;
    for (int i = 0; i < 3; i++) begin
      valid_i = fill_pat[i];
      instr   = mk(32'h40 + 32'(i));
      tick();
    end
    valid_i = '0;
    n_vec++;
    if (fu_valid_o !== 4'b0111 || fu_ready_o !== 4'b1110) begin
      n_err++;
      $display("FAIL flush_setup: valid=%b credit=%b, want 0111 1110",
               fu_valid_o, fu_ready_o);
    end
    flush_i    = 1'b1;
    valid_i    = 4'b0100;
    instr      = mk(32'h77);
    fu_ready_i = 4'b0001;
    tick();
    flush_i    = 1'b0;
    valid_i    = '0;
    fu_ready_i = '0;
    n_vec++;
    if (fu_valid_o !== 4'b0000 || fu_ready_o !== 4'b1111) begin
      n_err++;
      $display("FAIL flush: valid=%b credit=%b, want 0000 1111", fu_valid_o, fu_ready_o);
    end
    tick();
    n_vec++;
    if (fu_valid_o !== 4'b0000) begin
      n_err++;
      $display("FAIL flush_discard: valid=%b, want 0000", fu_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    fu_ready_i = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      valid_i = 4'b1000;
      instr   = mk(32'h30 + 32'(i));
      tick();
      n_vec++;
      if (fu_valid_o[3] !== 1'b1 || fu_instr[3] !== mk(32'h30 + 32'(i)) ||
          fu_ready_o[3] !== 1'b1) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: valid=%b pc=0x%0h credit=%b, want 1 0x%0h 1",
                 i, fu_valid_o[3], fu_instr[3].pc, fu_ready_o[3], 32'h30 + i);
      end
    end
    valid_i = '0;
    tick();
    fu_ready_i = '0;
    n_vec++;
    if (fu_valid_o[3] !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_back_empty: valid=%b, want 0", fu_valid_o[3]);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] rdy_pat = 16'b1011_0010_1101_0110;
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    while (recv < 10 && cyc < 200) begin
      fu_ready_i3 = {3'b000, rdy_pat[cyc % 16]};
      if (fu_valid3[0] && fu_ready_i3[0]) begin
        n_vec++;
        if (fu_instr3[0] !== mk(32'h100 + 32'(recv))) begin
          n_err++;
          $display("FAIL wrap_order[%0d]: pc=0x%0h, want 0x%0h",
                   recv, fu_instr3[0].pc, 32'h100 + recv);
        end
        recv++;
      end
      if (sent < 10 && fu_ready_o3[0]) begin
        valid3 = 4'b0001;
        instr3 = mk(32'h100 + 32'(sent));
        sent++;
      end else begin
        valid3 = '0;
      end
      tick();
      cyc++;
    end
    valid3      = '0;
    fu_ready_i3 = '0;
    n_vec++;
    if (recv != 10 || sent != 10) begin
      n_err++;
      $display("FAIL wrap_count: received %0d of %0d sent, want 10 of 10", recv, sent);
    end
    n_vec++;
    if (fu_valid3[0] !== 1'b0 || overflow3 !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_end: valid=%b ovf=%b, want 0 0", fu_valid3[0], overflow3);
    end
  endtask

  initial begin
    reset_i     = 1'b1;
    instr       = '0;
    valid_i     = '0;
    flush_i     = 1'b0;
    fu_ready_i  = '0;
    instr3      = '0;
    valid3      = '0;
    flush3      = 1'b0;
    fu_ready_i3 = '0;
    @(negedge clk);
    test_reset();
    test_single_issue();
    test_stall_full();
    test_full_enq_deq();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
